// File: rtl/interrupt_sequencer_pkg.sv
// rtl/interrupt_sequencer_pkg.sv - shared state encoding and constants for the interrupt sequencer
package interrupt_sequencer_pkg;

    localparam int STACK_WORD_W = 16;

    // Reset/interrupt vector, also used by the PC mux.
    localparam logic [31:0] DEFAULT_INT_VECTOR = 32'h0000_0000;

    typedef logic [3:0] seq_state_t;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_DRAIN      = 4'd1;
    localparam logic [3:0] ST_PUSH_PC_HI = 4'd2;
    localparam logic [3:0] ST_PUSH_PC_LO = 4'd3;
    localparam logic [3:0] ST_PUSH_FLAGS = 4'd4;
    localparam logic [3:0] ST_LOAD_VEC   = 4'd5;
    localparam logic [3:0] ST_POP_FLAGS  = 4'd6;
    localparam logic [3:0] ST_POP_PC_LO  = 4'd7;
    localparam logic [3:0] ST_POP_PC_HI  = 4'd8;
    localparam logic [3:0] ST_RESUME     = 4'd9;

endpackage

// File: rtl/interrupt_sequencer_int_edge_latch.sv
// rtl/interrupt_sequencer_int_edge_latch.sv - rising-edge detect on the interrupt line with a sticky pending flag
module int_edge_latch (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_int,
    input  logic i_clear,
    output logic o_pending
);

    logic int_d_q;
    logic int_d_d;
    logic pending_q;
    logic pending_d;

    // A new edge wins over a clear in the same cycle so no request is lost.
    always_comb begin
        int_d_d   = i_int;
        pending_d = (i_int & ~int_d_q) | (pending_q & ~i_clear);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            int_d_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            int_d_q   <= int_d_d;
            pending_q <= pending_d;
        end
    end

    assign o_pending = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - sequences interrupt entry (push PC/flags, vector) and RTI return (pop, resume)
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  FLAG_WIDTH = 3,
    parameter logic [PC_WIDTH-1:0] INT_VECTOR = DEFAULT_INT_VECTOR
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_int,
    input  logic                    i_rti,
    input  logic                    i_branch_decision,
    input  logic                    i_mem_busy,
    input  logic [PC_WIDTH-1:0]     i_pc_next,
    input  logic [FLAG_WIDTH-1:0]   i_flags,
    input  logic [15:0]             i_mem_rdata,
    output logic                    o_stall_f,
    output logic                    o_flush_f_d,
    output logic                    o_flush_d_em,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [15:0]             o_mem_wdata,
    output logic                    o_sp_dec,
    output logic                    o_sp_inc,
    output logic                    o_pc_load,
    output logic [PC_WIDTH-1:0]     o_pc_value,
    output logic                    o_flags_load,
    output logic [FLAG_WIDTH-1:0]   o_flags_value,
    output logic                    o_busy,
    output logic                    o_int_ack
);

    seq_state_t                    state_q, state_d;
    logic [PC_WIDTH-1:0]           pc_saved_q, pc_saved_d;
    logic [FLAG_WIDTH-1:0]         flags_saved_q, flags_saved_d;
    logic [FLAG_WIDTH-1:0]         flags_pop_q, flags_pop_d;
    logic [STACK_WORD_W-1:0]       lo_q, lo_d;
    logic [STACK_WORD_W-1:0]       hi_q, hi_d;
    logic                          pending;
    logic                          accept;

    int_edge_latch u_edge (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_int     (i_int),
        .i_clear   (accept),
        .o_pending (pending)
    );

    // RTI outranks a pending interrupt; entry also waits for the EM stage to be quiet.
    assign accept = (state_q == ST_IDLE) && !i_rti && pending
                    && !i_branch_decision && !i_mem_busy;

    always_comb begin
        state_d       = state_q;
        pc_saved_d    = pc_saved_q;
        flags_saved_d = flags_saved_q;
        flags_pop_d   = flags_pop_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        case (state_q)
            ST_IDLE: begin
                if (i_rti) begin
                    state_d = ST_POP_FLAGS;
                end else if (accept) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pc_saved_d    = i_pc_next;
                flags_saved_d = i_flags;
                state_d       = ST_PUSH_PC_HI;
            end
            ST_PUSH_PC_HI: state_d = ST_PUSH_PC_LO;
            ST_PUSH_PC_LO: state_d = ST_PUSH_FLAGS;
            ST_PUSH_FLAGS: state_d = ST_LOAD_VEC;
            ST_LOAD_VEC:   state_d = ST_IDLE;
            ST_POP_FLAGS: begin
                flags_pop_d = i_mem_rdata[FLAG_WIDTH-1:0];
                state_d     = ST_POP_PC_LO;
            end
            ST_POP_PC_LO: begin
                lo_d    = i_mem_rdata;
                state_d = ST_POP_PC_HI;
            end
            ST_POP_PC_HI: begin
                hi_d    = i_mem_rdata;
                state_d = ST_RESUME;
            end
            ST_RESUME:     state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            pc_saved_q    <= '0;
            flags_saved_q <= '0;
            flags_pop_q   <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
        end else begin
            state_q       <= state_d;
            pc_saved_q    <= pc_saved_d;
            flags_saved_q <= flags_saved_d;
            flags_pop_q   <= flags_pop_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
        end
    end

    // Outputs are silenced while reset is held so an aborted sequence never touches memory.
    always_comb begin
        o_stall_f     = 1'b0;
        o_flush_f_d   = 1'b0;
        o_flush_d_em  = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_wdata   = '0;
        o_sp_dec      = 1'b0;
        o_sp_inc      = 1'b0;
        o_pc_load     = 1'b0;
        o_pc_value    = '0;
        o_flags_load  = 1'b0;
        o_flags_value = '0;
        o_busy        = 1'b0;
        o_int_ack     = 1'b0;
        if (!i_reset) begin
            o_busy    = (state_q != ST_IDLE);
            o_int_ack = accept;
            case (state_q)
                ST_DRAIN: begin
                    o_stall_f    = 1'b1;
                    o_flush_f_d  = 1'b1;
                    o_flush_d_em = 1'b1;
                end
                ST_PUSH_PC_HI, ST_PUSH_PC_LO, ST_PUSH_FLAGS: begin
                    o_stall_f    = 1'b1;
                    o_flush_f_d  = 1'b1;
                    o_flush_d_em = 1'b1;
                    o_mem_req    = 1'b1;
                    o_mem_we     = 1'b1;
                    o_sp_dec     = 1'b1;
                    if (state_q == ST_PUSH_PC_HI) begin
                        o_mem_wdata = pc_saved_q[PC_WIDTH-1 -: STACK_WORD_W];
                    end else if (state_q == ST_PUSH_PC_LO) begin
                        o_mem_wdata = pc_saved_q[STACK_WORD_W-1:0];
                    end else begin
                        o_mem_wdata = STACK_WORD_W'(flags_saved_q);
                    end
                end
                ST_LOAD_VEC: begin
                    o_pc_load   = 1'b1;
                    o_pc_value  = INT_VECTOR;
                    o_flush_f_d = 1'b1;
                end
                ST_POP_FLAGS, ST_POP_PC_LO, ST_POP_PC_HI: begin
                    o_stall_f    = 1'b1;
                    o_flush_f_d  = 1'b1;
                    o_flush_d_em = 1'b1;
                    o_mem_req    = 1'b1;
                    o_sp_inc     = 1'b1;
                end
                ST_RESUME: begin
                    o_pc_load     = 1'b1;
                    o_pc_value    = PC_WIDTH'({hi_q, lo_q});
                    o_flags_load  = 1'b1;
                    o_flags_value = flags_pop_q;
                    o_flush_f_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
